// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit: aligns byte/half/word/double accesses onto a word-wide memory port
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_funct3,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_data,
  output logic                resp_err,
  output logic                mem_read,
  output logic                mem_write,
  output logic [XLEN-1:0]     mem_address,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_byte_enable,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_resp
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic               write_q, write_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               resp_err_q, resp_err_d;
  logic [XLEN-1:0]    resp_data_q, resp_data_d;

  logic               illegal, misaligned, in_access, expired;
  logic [OFF_W-1:0]   amask, off_q;
  logic [NB-1:0]      be_size;
  logic [XLEN-1:0]    dmask, rshift, load_ext;

  function automatic logic [OFF_W-1:0] align_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return '0;
      2'd1:    return OFF_W'(1);
      2'd2:    return OFF_W'(3);
      default: return OFF_W'(7);
    endcase
  endfunction

  function automatic logic [NB-1:0] size_be(input logic [1:0] sz);
    case (sz)
      2'd0:    return NB'(1);
      2'd1:    return NB'(3);
      2'd2:    return NB'(15);
      default: return NB'(255);
    endcase
  endfunction

  always_comb begin
    amask      = align_mask(req_funct3[1:0]);
    illegal    = (req_funct3 == 3'b111) ||
                 ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
    misaligned = (req_addr[OFF_W-1:0] & amask) != '0;

    // Memory-side signals are derived from the registered request, so they stay put for all of ACCESS.
    off_q     = addr_q[OFF_W-1:0];
    be_size   = size_be(funct3_q[1:0]);
    in_access = (state_q == ACCESS);
    dmask     = '0;
    for (int i = 0; i < NB; i++) dmask[8*i +: 8] = {8{be_size[i]}};

    mem_read        = in_access && !write_q;
    mem_write       = in_access && write_q;
    mem_address     = in_access ? {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
    mem_byte_enable = in_access ? (write_q ? (be_size << off_q) : '1) : '0;
    mem_wdata       = (in_access && write_q) ? ((wdata_q & dmask) << {off_q, 3'b000}) : '0;

    rshift = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = XLEN'($signed(rshift[7:0]));
      3'b001:  load_ext = XLEN'($signed(rshift[15:0]));
      3'b010:  load_ext = XLEN'($signed(rshift[31:0]));
      3'b100:  load_ext = XLEN'(rshift[7:0]);
      3'b101:  load_ext = XLEN'(rshift[15:0]);
      3'b110:  load_ext = XLEN'(rshift[31:0]);
      default: load_ext = rshift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    resp_err_d  = resp_err_q;
    resp_data_d = resp_data_q;
    req_ready   = (state_q == IDLE);
    resp_valid  = (state_q == RESP);
    expired     = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cnt_d    = '0;
          if (illegal || misaligned) begin
            state_d     = RESP;
            resp_err_d  = 1'b1;
            resp_data_d = '0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // A response arriving on the expiry cycle still completes normally.
        if (mem_resp) begin
          state_d     = RESP;
          resp_err_d  = 1'b0;
          resp_data_d = write_q ? '0 : load_ext;
        end else if (expired) begin
          state_d     = RESP;
          resp_err_d  = 1'b1;
          resp_data_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_err  = resp_err_q;
  assign resp_data = resp_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed bench for load_store_unit at XLEN 32 (TIMEOUT 4) and XLEN 64
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid32 = 1'b0, req_valid64 = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [63:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic        mem_resp = 1'b0;

  logic        r32_ready, r32_valid, r32_err, m32_read, m32_write;
  logic [31:0] r32_data, m32_addr, m32_wdata;
  logic [3:0]  m32_be;
  logic        r64_ready, r64_valid, r64_err, m64_read, m64_write;
  logic [63:0] r64_data, m64_addr, m64_wdata;
  logic [7:0]  m64_be;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid32), .req_ready(r32_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
    .resp_valid(r32_valid), .resp_data(r32_data), .resp_err(r32_err),
    .mem_read(m32_read), .mem_write(m32_write), .mem_address(m32_addr),
    .mem_wdata(m32_wdata), .mem_byte_enable(m32_be),
    .mem_rdata(mem_rdata[31:0]), .mem_resp(mem_resp)
  );

  load_store_unit #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid64), .req_ready(r64_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(r64_valid), .resp_data(r64_data), .resp_err(r64_err),
    .mem_read(m64_read), .mem_write(m64_write), .mem_address(m64_addr),
    .mem_wdata(m64_wdata), .mem_byte_enable(m64_be),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int reads;
    int seen;

    cyc(); cyc();
    chk("rst_ready",   r32_ready, 1);
    chk("rst_rvalid",  r32_valid, 0);
    chk("rst_err",     r32_err, 0);
    chk("rst_rdata",   r32_data, 0);
    chk("rst_strobes", {m32_read, m32_write}, 0);
    chk("rst_addr",    m32_addr, 0);
    chk("rst_wdata",   m32_wdata, 0);
    chk("rst_be",      m32_be, 0);
    rst = 1'b1;
    cyc();

    // LB 0x1003, three wait cycles, response on the timeout-expiry cycle
    req_valid32 = 1'b1; req_write = 1'b0; req_funct3 = 3'b000; req_addr = 64'h1003;
    cyc();
    req_valid32 = 1'b0;
    chk("lb_read",   {m32_read, m32_write}, 2'b10);
    chk("lb_addr",   m32_addr, 32'h1000);
    chk("lb_be",     m32_be, 4'hF);
    chk("lb_ready",  r32_ready, 0);
    cyc(); cyc();
    chk("lb_hold_addr", m32_addr, 32'h1000);
    cyc();
    chk("lb_read4",  m32_read, 1);
    mem_resp = 1'b1; mem_rdata = 64'h80FF_1234;
    cyc();
    mem_resp = 1'b0;
    chk("lb_rvalid", r32_valid, 1);
    chk("lb_data",   r32_data, 32'hFFFF_FF80);
    chk("lb_err",    r32_err, 0);
    chk("lb_drop",   m32_read, 0);
    cyc();
    chk("lb_pulse",  r32_valid, 0);
    chk("lb_idle",   r32_ready, 1);

    // SH 0x2002
    req_valid32 = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 64'h2002; req_wdata = 64'h0000_BEEF;
    cyc();
    req_valid32 = 1'b0;
    chk("sh_strobe", {m32_read, m32_write}, 2'b01);
    chk("sh_addr",   m32_addr, 32'h2000);
    chk("sh_be",     m32_be, 4'hC);
    chk("sh_wdata",  m32_wdata, 32'hBEEF_0000);
    mem_resp = 1'b1;
    cyc();
    mem_resp = 1'b0;
    chk("sh_rvalid", r32_valid, 1);
    chk("sh_data",   r32_data, 0);
    chk("sh_err",    r32_err, 0);
    chk("sh_drop",   m32_write, 0);
    cyc();

    // SB 0x1001: lanes outside the byte must be zero
    req_valid32 = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 64'h1001; req_wdata = 64'hFFFF_FFA5;
    cyc();
    req_valid32 = 1'b0;
    chk("sb_be",    m32_be, 4'h2);
    chk("sb_wdata", m32_wdata, 32'h0000_A500);
    mem_resp = 1'b1;
    cyc();
    mem_resp = 1'b0;
    chk("sb_rvalid", r32_valid, 1);
    cyc();

    // LW 0x3001 misaligned
    req_valid32 = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 64'h3001;
    cyc();
    req_valid32 = 1'b0;
    chk("lwmis_strobe", {m32_read, m32_write}, 0);
    chk("lwmis_rvalid", r32_valid, 1);
    chk("lwmis_err",    r32_err, 1);
    chk("lwmis_data",   r32_data, 0);
    cyc();
    chk("lwmis_idle",   r32_ready, 1);

    // LD on XLEN=32 is illegal
    req_valid32 = 1'b1; req_funct3 = 3'b011; req_addr = 64'h0;
    cyc();
    req_valid32 = 1'b0;
    chk("ld32_strobe", m32_read, 0);
    chk("ld32_err",    {r32_valid, r32_err}, 2'b11);
    cyc();

    // Timeout: mem_read for exactly 4 cycles, then error
    req_valid32 = 1'b1; req_funct3 = 3'b010; req_addr = 64'h4000;
    cyc();
    req_valid32 = 1'b0;
    reads = 0; seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (m32_read) reads++;
      if (r32_valid) seen = 1;
      else cyc();
    end
    chk("to_seen",   seen, 1);
    chk("to_reads",  reads, 4);
    chk("to_err",    r32_err, 1);
    cyc();
    chk("to_idle",   {r32_ready, r32_valid}, 2'b10);

    // XLEN=64 LD 0x8
    req_valid64 = 1'b1; req_write = 1'b0; req_funct3 = 3'b011; req_addr = 64'h8;
    cyc();
    req_valid64 = 1'b0;
    chk("ld64_read", m64_read, 1);
    chk("ld64_addr", m64_addr, 64'h8);
    chk("ld64_be",   m64_be, 8'hFF);
    mem_resp = 1'b1; mem_rdata = 64'hABCD_0000_0000_0000;
    cyc();
    mem_resp = 1'b0;
    chk("ld64_data", r64_data, 64'hABCD_0000_0000_0000);
    chk("ld64_err",  {r64_valid, r64_err}, 2'b10);
    cyc();

    // XLEN=64 LHU 0xE
    req_valid64 = 1'b1; req_funct3 = 3'b101; req_addr = 64'hE;
    cyc();
    req_valid64 = 1'b0;
    chk("lhu_addr", m64_addr, 64'h8);
    mem_resp = 1'b1;
    cyc();
    mem_resp = 1'b0;
    chk("lhu_data", r64_data, 64'h0000_0000_0000_ABCD);
    chk("lhu_err",  {r64_valid, r64_err}, 2'b10);
    cyc();

    // Reset mid-ACCESS aborts with no response
    req_valid32 = 1'b1; req_funct3 = 3'b000; req_addr = 64'h5000;
    cyc();
    req_valid32 = 1'b0;
    chk("abort_read", m32_read, 1);
    rst = 1'b0;
    cyc();
    chk("abort_drop",   {m32_read, m32_write}, 0);
    chk("abort_rvalid", r32_valid, 0);
    chk("abort_addr",   m32_addr, 0);
    rst = 1'b1;
    cyc();
    chk("abort_ready",  r32_ready, 1);
    chk("abort_rvalid2", r32_valid, 0);
    cyc();
    chk("abort_rvalid3", r32_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
